// File: rtl/framebuffer_pingpong.sv
// rtl/framebuffer_pingpong.sv - two-page asymmetric framebuffer with frame-synchronous page swap
// Define FRAMEBUFFER_CLEAR_EN to build the back-page zero-fill engine (Busy, ClearDone, WrDropped).
module framebuffer_pingpong #(
   parameter  int WR_WIDTH      = 8,
   parameter  int RD_RATIO      = 2,
   parameter  int WR_ADDR_WIDTH = 12,
   localparam int LANE_BITS     = $clog2(RD_RATIO),
   localparam int RD_ADDR_WIDTH = WR_ADDR_WIDTH - LANE_BITS,
   localparam int RD_WIDTH      = WR_WIDTH * RD_RATIO
) (
   input  logic                     Clock,
   input  logic                     ResetN,
   input  logic                     WrEn,
   input  logic [WR_ADDR_WIDTH-1:0] WrAddr,
   input  logic [WR_WIDTH-1:0]      WrData,
   input  logic                     RdEn,
   input  logic [RD_ADDR_WIDTH-1:0] RdAddr,
   output logic [RD_WIDTH-1:0]      RdData,
   output logic                     RdValid,
   input  logic                     SwapReq,
   input  logic                     FrameEnd,
   output logic                     SwapPending,
   output logic                     SwapAck,
   output logic                     ActivePage,
   input  logic                     ClearReq,
   output logic                     Busy,
   output logic                     ClearDone,
   output logic                     WrDropped
);
   localparam int BANK_DEPTH = 2 ** (RD_ADDR_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      CLEARING = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  active_page_q, active_page_d;
   logic                  swap_pending_q, swap_pending_d;
   logic                  swap_ack_q, swap_ack_d;
   logic [RD_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                     mem_we;
   logic [WR_ADDR_WIDTH-1:0] mem_waddr;
   logic [WR_WIDTH-1:0]      mem_wdata;
   logic [WR_ADDR_WIDTH-1:0] lane_sel;
   logic [RD_ADDR_WIDTH:0]   bank_waddr;
   logic [RD_ADDR_WIDTH:0]   bank_raddr;
   logic [RD_WIDTH-1:0]      rd_word;

`ifdef FRAMEBUFFER_CLEAR_EN
   logic [WR_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                     busy_q, busy_d;
   logic                     clear_done_q, clear_done_d;
   logic                     wr_dropped_q, wr_dropped_d;
`else
   logic unused_clear_req;
   assign unused_clear_req = ClearReq;
`endif

   // The clear engine owns the write port while it runs; host writes are discarded.
   always_comb begin
      mem_we    = WrEn;
      mem_waddr = WrAddr;
      mem_wdata = WrData;
`ifdef FRAMEBUFFER_CLEAR_EN
      if (state_q == CLEARING) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end
`endif
   end

   assign lane_sel   = mem_waddr & WR_ADDR_WIDTH'(RD_RATIO - 1);
   assign bank_waddr = {~active_page_q, RD_ADDR_WIDTH'(mem_waddr >> LANE_BITS)};
   assign bank_raddr = {active_page_q, RdAddr};

   for (genvar g = 0; g < RD_RATIO; g++) begin : g_lane
      logic [WR_WIDTH-1:0] bank [BANK_DEPTH];

      always_ff @(posedge Clock) begin
         if (ResetN && mem_we && (lane_sel == WR_ADDR_WIDTH'(g)))
            bank[bank_waddr] <= mem_wdata;
      end

      assign rd_word[g*WR_WIDTH +: WR_WIDTH] = bank[bank_raddr];
   end

   always_comb begin
      state_d       = state_q;
      active_page_d = active_page_q;
      swap_ack_d    = 1'b0;
      rd_data_d     = RdEn ? rd_word : rd_data_q;
      rd_valid_d    = RdEn;
`ifdef FRAMEBUFFER_CLEAR_EN
      clr_cnt_d     = '0;
      clear_done_d  = 1'b0;
      wr_dropped_d  = wr_dropped_q | ((state_q == CLEARING) & WrEn);
`endif
      case (state_q)
         IDLE: begin
`ifdef FRAMEBUFFER_CLEAR_EN
            if (ClearReq) begin
               state_d = CLEARING;
            end else
`endif
            if (SwapReq) begin
               if (FrameEnd) begin
                  active_page_d = ~active_page_q;
                  swap_ack_d    = 1'b1;
               end else begin
                  state_d = ARMED;
               end
            end
         end
         ARMED: begin
            if (FrameEnd) begin
               active_page_d = ~active_page_q;
               swap_ack_d    = 1'b1;
               state_d       = IDLE;
            end
         end
`ifdef FRAMEBUFFER_CLEAR_EN
         CLEARING: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               clr_cnt_d    = '0;
               clear_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      swap_pending_d = (state_d == ARMED);
`ifdef FRAMEBUFFER_CLEAR_EN
      busy_d = (state_d == CLEARING);
`endif
   end

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state_q        <= IDLE;
         active_page_q  <= 1'b0;
         swap_pending_q <= 1'b0;
         swap_ack_q     <= 1'b0;
         rd_data_q      <= '0;
         rd_valid_q     <= 1'b0;
`ifdef FRAMEBUFFER_CLEAR_EN
         clr_cnt_q      <= '0;
         busy_q         <= 1'b0;
         clear_done_q   <= 1'b0;
         wr_dropped_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         active_page_q  <= active_page_d;
         swap_pending_q <= swap_pending_d;
         swap_ack_q     <= swap_ack_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
`ifdef FRAMEBUFFER_CLEAR_EN
         clr_cnt_q      <= clr_cnt_d;
         busy_q         <= busy_d;
         clear_done_q   <= clear_done_d;
         wr_dropped_q   <= wr_dropped_d;
`endif
      end
   end

   assign RdData      = rd_data_q;
   assign RdValid     = rd_valid_q;
   assign SwapPending = swap_pending_q;
   assign SwapAck     = swap_ack_q;
   assign ActivePage  = active_page_q;
`ifdef FRAMEBUFFER_CLEAR_EN
   assign Busy        = busy_q;
   assign ClearDone   = clear_done_q;
   assign WrDropped   = wr_dropped_q;
`else
   assign Busy        = 1'b0;
   assign ClearDone   = 1'b0;
   assign WrDropped   = 1'b0;
`endif

endmodule

// File: tb/tb_framebuffer_pingpong.sv
// tb/tb_framebuffer_pingpong.sv - directed self-checking bench for framebuffer_pingpong
module tb_framebuffer_pingpong;
   logic        Clock = 1'b0;
   logic        ResetN;
   logic        WrEn;
   logic [3:0]  WrAddr;
   logic [7:0]  WrData;
   logic        RdEn;
   logic [2:0]  RdAddr;
   logic [15:0] RdData;
   logic        RdValid;
   logic        SwapReq;
   logic        FrameEnd;
   logic        SwapPending;
   logic        SwapAck;
   logic        ActivePage;
   logic        ClearReq;
   logic        Busy;
   logic        ClearDone;
   logic        WrDropped;

   int n_checks = 0;
   int n_fail   = 0;

   framebuffer_pingpong #(
      .WR_WIDTH      (8),
      .RD_RATIO      (2),
      .WR_ADDR_WIDTH (4)
   ) dut (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .WrEn        (WrEn),
      .WrAddr      (WrAddr),
      .WrData      (WrData),
      .RdEn        (RdEn),
      .RdAddr      (RdAddr),
      .RdData      (RdData),
      .RdValid     (RdValid),
      .SwapReq     (SwapReq),
      .FrameEnd    (FrameEnd),
      .SwapPending (SwapPending),
      .SwapAck     (SwapAck),
      .ActivePage  (ActivePage),
      .ClearReq    (ClearReq),
      .Busy        (Busy),
      .ClearDone   (ClearDone),
      .WrDropped   (WrDropped)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic write(input logic [3:0] a, input logic [7:0] d);
      WrEn = 1'b1; WrAddr = a; WrData = d;
      step();
      WrEn = 1'b0;
   endtask

   task automatic read(input logic [2:0] a);
      RdEn = 1'b1; RdAddr = a;
      step();
      RdEn = 1'b0;
   endtask

   task automatic swap_now();
      SwapReq = 1'b1; FrameEnd = 1'b1;
      step();
      SwapReq = 1'b0; FrameEnd = 1'b0;
   endtask

   // ClearReq must already be driven; counts Busy-high cycles, optionally pokes a host write.
   task automatic run_clear(input int wr_at, output int cycles, output logic ack_seen);
      cycles = 0; ack_seen = 1'b0;
      step();
      ClearReq = 1'b0; SwapReq = 1'b0;
      while (Busy && cycles < 40) begin
         cycles++;
         if (SwapAck) ack_seen = 1'b1;
         WrEn = (cycles == wr_at); WrAddr = 4'h0; WrData = 8'hEE;
         step();
      end
      WrEn = 1'b0;
   endtask

   initial begin
      int   cyc;
      logic ack;

      ResetN = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
      RdEn = 1'b0; RdAddr = '0; SwapReq = 1'b0; FrameEnd = 1'b0; ClearReq = 1'b0;
      repeat (3) step();
      check_eq("rst_rddata", RdData, 0);
      check_eq("rst_rdvalid", RdValid, 0);
      check_eq("rst_pending", SwapPending, 0);
      check_eq("rst_ack", SwapAck, 0);
      check_eq("rst_page", ActivePage, 0);
      check_eq("rst_busy", Busy, 0);
      check_eq("rst_done", ClearDone, 0);
      check_eq("rst_dropped", WrDropped, 0);
      ResetN = 1'b1;
      step();

      // lane packing through a one-cycle-deferred swap
      write(4'h0, 8'hA5);
      write(4'h1, 8'h3C);
      write(4'h2, 8'h11);
      write(4'h3, 8'h22);
      SwapReq = 1'b1;
      step();
      SwapReq = 1'b0;
      check_eq("arm_pending", SwapPending, 1);
      check_eq("arm_page", ActivePage, 0);
      FrameEnd = 1'b1;
      step();
      FrameEnd = 1'b0;
      check_eq("commit_page", ActivePage, 1);
      check_eq("commit_ack", SwapAck, 1);
      check_eq("commit_pending", SwapPending, 0);
      read(3'h0);
      check_eq("ack_pulse", SwapAck, 0);
      check_eq("pack0_data", RdData, 16'h3CA5);
      check_eq("pack0_valid", RdValid, 1);
      read(3'h1);
      check_eq("pack1_data", RdData, 16'h2211);
      step();
      check_eq("hold_valid", RdValid, 0);
      check_eq("hold_data", RdData, 16'h2211);

      // immediate swap when SwapReq meets FrameEnd in IDLE
      swap_now();
      check_eq("imm_page", ActivePage, 0);
      check_eq("imm_ack", SwapAck, 1);
      check_eq("imm_pending", SwapPending, 0);

      // deferred swap with a redundant second request while armed
      SwapReq = 1'b1;
      step();
      SwapReq = 1'b0;
      for (int i = 0; i < 14; i++) begin
         SwapReq = (i == 4);
         check_eq("defer_pending", SwapPending, 1);
         check_eq("defer_page", ActivePage, 0);
         check_eq("defer_ack", SwapAck, 0);
         step();
      end
      SwapReq = 1'b0;
      FrameEnd = 1'b1;
      step();
      FrameEnd = 1'b0;
      check_eq("defer_commit_page", ActivePage, 1);
      check_eq("defer_commit_ack", SwapAck, 1);
      FrameEnd = 1'b1;
      step();
      FrameEnd = 1'b0;
      check_eq("idle_fe_page", ActivePage, 1);
      check_eq("idle_fe_ack", SwapAck, 0);
      check_eq("idle_fe_pending", SwapPending, 0);

      // write and read in the swap-commit cycle: write lands in new front, read sees old front
      write(4'h5, 8'h66);
      WrEn = 1'b1; WrAddr = 4'h4; WrData = 8'h77;
      RdEn = 1'b1; RdAddr = 3'h0;
      swap_now();
      WrEn = 1'b0; RdEn = 1'b0;
      check_eq("edge_read_old", RdData, 16'h3CA5);
      check_eq("edge_page", ActivePage, 0);
      read(3'h2);
      check_eq("edge_write_new", RdData, 16'h6677);

      // reset while armed drops the swap
      SwapReq = 1'b1;
      step();
      SwapReq = 1'b0;
      check_eq("armed_pre_rst", SwapPending, 1);
      ResetN = 1'b0;
      step();
      ResetN = 1'b1;
      check_eq("armed_rst_pending", SwapPending, 0);
      FrameEnd = 1'b1;
      step();
      FrameEnd = 1'b0;
      check_eq("armed_rst_ack", SwapAck, 0);
      check_eq("armed_rst_page", ActivePage, 0);

`ifdef FRAMEBUFFER_CLEAR_EN
      for (int a = 0; a < 16; a++) write(4'(a), 8'hFF);
      ClearReq = 1'b1; SwapReq = 1'b1;
      run_clear(10, cyc, ack);
      check_eq("clr_busy_cycles", cyc, 16);
      check_eq("clr_done", ClearDone, 1);
      check_eq("clr_busy_end", Busy, 0);
      check_eq("clr_no_ack", ack, 0);
      check_eq("clr_page", ActivePage, 0);
      check_eq("clr_dropped", WrDropped, 1);
      step();
      check_eq("clr_done_pulse", ClearDone, 0);
      check_eq("clr_no_pending", SwapPending, 0);
      swap_now();
      check_eq("clr_swap_page", ActivePage, 1);
      for (int a = 0; a < 8; a++) begin
         read(3'(a));
         check_eq("clr_zero", RdData, 16'h0000);
      end

      // reset mid-clear, then a fresh full-length clear
      ClearReq = 1'b1;
      step();
      ClearReq = 1'b0;
      repeat (5) step();
      check_eq("mid_busy", Busy, 1);
      ResetN = 1'b0;
      step();
      ResetN = 1'b1;
      check_eq("mid_rst_busy", Busy, 0);
      check_eq("mid_rst_done", ClearDone, 0);
      check_eq("mid_rst_dropped", WrDropped, 0);
      step();
      check_eq("mid_rst_done2", ClearDone, 0);
      ClearReq = 1'b1;
      run_clear(0, cyc, ack);
      check_eq("restart_cycles", cyc, 16);
      check_eq("restart_done", ClearDone, 1);
      check_eq("restart_dropped", WrDropped, 0);
`else
      ClearReq = 1'b1;
      step();
      check_eq("noclr_busy", Busy, 0);
      SwapReq = 1'b1; FrameEnd = 1'b1;
      step();
      ClearReq = 1'b0; SwapReq = 1'b0; FrameEnd = 1'b0;
      check_eq("noclr_swap_page", ActivePage, 1);
      check_eq("noclr_swap_ack", SwapAck, 1);
      check_eq("noclr_done", ClearDone, 0);
      write(4'h0, 8'h5A);
      check_eq("noclr_dropped", WrDropped, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
